mult4_ctrl_fsm: RTL and testbench



---
 rtl/mult4_ctrl_pkg.sv | 32 +++
 rtl/mult4_ctrl_fsm_if.sv | 16 +
 rtl/mult4_ctrl_decode.sv | 33 +++
 rtl/mult4_ctrl_fsm.sv | 51 +++++
 tb/tb_mult4_ctrl_fsm.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mult4_ctrl_pkg.sv
// Shared types for the sequential 4x4 multiplier control unit: state encoding,
// decoded control word and the partial-product cycle count.
package mult4_ctrl_pkg;

  localparam int PP_CYCLES = 4;

  // Code 7 is deliberately left out; it is treated as IDLE everywhere.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_LOAD = 3'd2,
    ST_PP0  = 3'd3,
    ST_PP1  = 3'd4,
    ST_PP2  = 3'd5,
    ST_PP3  = 3'd6
  } state_e;

  typedef struct packed {
    logic ready;
    logic ld2;
    logic ld1;
    logic sig_rst;
    logic s2;
    logic s1;
    logic s0;
  } ctrl_t;

  function automatic logic is_pp(input state_e st);
    return (int'(st) >= int'(ST_PP0)) && (int'(st) < int'(ST_PP0) + PP_CYCLES);
  endfunction

endpackage

// File: rtl/mult4_ctrl_fsm_if.sv
// Start/ready handshake plus decoded datapath strobes between the requester,
// the control FSM and the multiplier datapath.
interface mult4_ctrl_fsm_if;
  logic       start;
  logic [2:0] ps;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       sig_rst;
  logic       ld1;
  logic       ld2;
  logic       ready;

  modport master (output start, input ps, s0, s1, s2, sig_rst, ld1, ld2, ready);
  modport slave  (input start, output ps, s0, s1, s2, sig_rst, ld1, ld2, ready);
endinterface

// File: rtl/mult4_ctrl_decode.sv
// Moore output decoder: state -> PP mux selects, load/clear strobes and ready.
module mult4_ctrl_decode
  import mult4_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  logic [2:0] st_raw;
  logic [2:0] pp_idx;

  always_comb begin
    ctrl   = '0;
    st_raw = state;
    pp_idx = st_raw - 3'(ST_PP0);
    case (state)
      ST_ARM: ;
      ST_LOAD: begin
        ctrl.ld1     = 1'b1;
        ctrl.sig_rst = 1'b1;
      end
      ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
        // PP index walks {s1,s0} = 00,01,10,11; mixed halves are the cross terms.
        ctrl.ld2 = 1'b1;
        ctrl.s0  = pp_idx[0];
        ctrl.s1  = pp_idx[1];
        ctrl.s2  = pp_idx[0] ^ pp_idx[1];
      end
      default: ctrl.ready = 1'b1;
    endcase
  end

endmodule

// File: rtl/mult4_ctrl_fsm.sv
// Control FSM for the sequential 4x4 multiplier: IDLE->ARM->LOAD->PP0..PP3.
// Optional MULT4_CTRL_ABORT_EN: start seen during PP0..PP3 re-arms the unit.
module mult4_ctrl_fsm
  import mult4_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  mult4_ctrl_fsm_if.slave  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = bus.start ? ST_ARM : ST_IDLE;
      // Launch only on the falling half of a start pulse; a held start stays armed.
      ST_ARM:  state_d = bus.start ? ST_ARM : ST_LOAD;
      ST_LOAD: state_d = ST_PP0;
      ST_PP0:  state_d = ST_PP1;
      ST_PP1:  state_d = ST_PP2;
      ST_PP2:  state_d = ST_PP3;
      ST_PP3:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef MULT4_CTRL_ABORT_EN
    if (is_pp(state_q) && bus.start) state_d = ST_ARM;
`endif
  end

  mult4_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.ps      = state_q;
  assign bus.s0      = ctrl.s0;
  assign bus.s1      = ctrl.s1;
  assign bus.s2      = ctrl.s2;
  assign bus.sig_rst = ctrl.sig_rst;
  assign bus.ld1     = ctrl.ld1;
  assign bus.ld2     = ctrl.ld2;
  assign bus.ready   = ctrl.ready;

endmodule

// File: tb/tb_mult4_ctrl_fsm.sv
// Directed bench for mult4_ctrl_fsm: reset, held start, full sequence,
// async abort, illegal state recovery and start during PP cycles.
module tb_mult4_ctrl_fsm;
  import mult4_ctrl_pkg::*;

  logic clk;
  logic clr;
  int   n_chk;
  int   n_err;

  mult4_ctrl_fsm_if bus();

  mult4_ctrl_fsm dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Expected {ready,ld2,ld1,sig_rst,s2,s1,s0} per state code, from the output table.
  function automatic logic [7:0] exp_ctrl(input int ps);
    case (ps)
      1:       return 8'b0000_0000;
      2:       return 8'b0001_1000;
      3:       return 8'b0010_0000;
      4:       return 8'b0010_0101;
      5:       return 8'b0010_0110;
      6:       return 8'b0010_0011;
      default: return 8'b0100_0000;
    endcase
  endfunction

  function automatic logic [7:0] act_ctrl();
    return {1'b0, bus.ready, bus.ld2, bus.ld1, bus.sig_rst, bus.s2, bus.s1, bus.s0};
  endfunction

  task automatic chk_state(input string tag, input int ps);
    chk({tag, "_ps"}, {5'd0, bus.ps}, 8'(ps));
    chk({tag, "_ctl"}, act_ctrl(), exp_ctrl(ps));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (bus.ps == 3'd0) break;
      @(negedge clk);
    end
    chk("wait_idle", {5'd0, bus.ps}, 8'd0);
  endtask

  // One-cycle start pulse from IDLE; expects the full 1..6,0 walk.
  task automatic run_seq(input string tag);
    int exp_ps[7] = '{1, 2, 3, 4, 5, 6, 0};
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk_state($sformatf("%s_%0d", tag, i), exp_ps[i]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clr = 1'b0;
    bus.start = 1'bx;
    repeat (3) @(negedge clk);
    chk_state("rst", 0);

    // Held start never launches.
    clr = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_state($sformatf("hold_%0d", i), 1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk_state("hold_rel", 2);
    wait_idle();

    run_seq("seq");

    // Async clear while in PP1, between clock edges.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10 && bus.ps != 3'd4; i++) @(negedge clk);
    chk_state("pre_clr", 4);
    #2 clr = 1'b0;
    #1 chk_state("async_clr", 0);
    #1 clr = 1'b1;
    run_seq("post_clr");

    // Illegal code 7 decodes as IDLE and recovers on the next edge.
    @(negedge clk);
    force dut.state_q = state_e'(3'd7);
    #1 chk({5'd0, bus.ps} == 8'd7 ? "ill_ps" : "ill_ps", {5'd0, bus.ps}, 8'd7);
    chk("ill_ctl", act_ctrl(), exp_ctrl(7));
    release dut.state_q;
    @(negedge clk);
    chk_state("ill_rec", 0);

    // Start raised during PP1.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10 && bus.ps != 3'd4; i++) @(negedge clk);
    chk_state("abort_pp1", 4);
    bus.start = 1'b1;
    @(negedge clk);
`ifdef MULT4_CTRL_ABORT_EN
    chk_state("abort_arm", 1);
    bus.start = 1'b0;
    @(negedge clk);
    chk_state("abort_load", 2);
`else
    chk_state("ign_pp2", 5);
    @(negedge clk);
    chk_state("ign_pp3", 6);
    @(negedge clk);
    chk_state("ign_idle", 0);
    @(negedge clk);
    chk_state("ign_arm", 1);
    bus.start = 1'b0;
`endif
    @(negedge clk);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
